// File: rtl/transposicao_matriz_seq.sv
// rtl/transposicao_matriz_seq.sv - sequential ROWS x COLS signed matrix transposer, one element per clock
// Define TRANSPOSE_SYMM_CHECK_EN to add the simetrica symmetry flag output.
module transposicao_matriz_seq #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ROWS*COLS*DATA_W-1:0]   matrix_A,
    output logic [ROWS*COLS*DATA_W-1:0]   m_transposta_A,
    output logic                          busy,
    output logic                          done
`ifdef TRANSPOSE_SYMM_CHECK_EN
    ,
    output logic                          simetrica
`endif
);

    localparam int NB = ROWS * COLS * DATA_W;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state;
    logic [RW-1:0]   r;
    logic [CW-1:0]   c;
    logic [NB-1:0]   src;
    logic [NB-1:0]   shadow;
    int              rd_idx;
    int              wr_idx;
    logic            last_c;
    logic            last_r;

    always_comb begin
        rd_idx = int'(r) * COLS + int'(c);
        wr_idx = int'(c) * ROWS + int'(r);
        last_c = (c == CW'(COLS - 1));
        last_r = (r == RW'(ROWS - 1));
    end

`ifdef TRANSPOSE_SYMM_CHECK_EN
    logic symm_acc;
    logic elem_eq;

    // The mirror element only exists for square matrices; otherwise the flag is forced low.
    generate
        if (ROWS == COLS) begin : g_square
            int mir_idx;
            always_comb begin
                mir_idx = int'(c) * COLS + int'(r);
                elem_eq = (src[rd_idx*DATA_W +: DATA_W] == src[mir_idx*DATA_W +: DATA_W]);
            end
        end else begin : g_rect
            assign elem_eq = 1'b0;
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            r              <= '0;
            c              <= '0;
            src            <= '0;
            shadow         <= '0;
            m_transposta_A <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef TRANSPOSE_SYMM_CHECK_EN
            symm_acc       <= 1'b0;
            simetrica      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src   <= matrix_A;
                        r     <= '0;
                        c     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef TRANSPOSE_SYMM_CHECK_EN
                        symm_acc <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    shadow[wr_idx*DATA_W +: DATA_W] <= src[rd_idx*DATA_W +: DATA_W];
`ifdef TRANSPOSE_SYMM_CHECK_EN
                    symm_acc <= symm_acc & elem_eq;
`endif
                    if (last_c) begin
                        c <= '0;
                        if (last_r) begin
                            r     <= '0;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                FIN: begin
                    // Publish the whole shadow at once so the output never shows a partial result.
                    m_transposta_A <= shadow;
                    done           <= 1'b1;
                    state          <= IDLE;
`ifdef TRANSPOSE_SYMM_CHECK_EN
                    simetrica      <= (ROWS == COLS) && symm_acc;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transposicao_matriz_seq.sv
// tb/tb_transposicao_matriz_seq.sv - directed scoreboard bench for transposicao_matriz_seq (5x5, 2x3, 1x1)
module tb_transposicao_matriz_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st0, st1, st2;
    logic [199:0] m0;
    logic [47:0]  m1;
    logic [7:0]   m2;
    logic [199:0] o0;
    logic [47:0]  o1;
    logic [7:0]   o2;
    logic         b0, b1, b2, d0, d1, d2;
`ifdef TRANSPOSE_SYMM_CHECK_EN
    logic         s0, s1, s2;
`endif

    logic [2:0]   bz, dn;
    logic [199:0] ov [3];
    logic [199:0] q [$];
    int           passed = 0;
    int           total  = 0;

    assign bz    = {b2, b1, b0};
    assign dn    = {d2, d1, d0};
    assign ov[0] = o0;
    assign ov[1] = {152'b0, o1};
    assign ov[2] = {192'b0, o2};

    always #5 clk = ~clk;

    transposicao_matriz_seq #(.ROWS(5), .COLS(5), .DATA_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .matrix_A(m0), .m_transposta_A(o0),
        .busy(b0), .done(d0)
`ifdef TRANSPOSE_SYMM_CHECK_EN
        , .simetrica(s0)
`endif
    );

    transposicao_matriz_seq #(.ROWS(2), .COLS(3), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .matrix_A(m1), .m_transposta_A(o1),
        .busy(b1), .done(d1)
`ifdef TRANSPOSE_SYMM_CHECK_EN
        , .simetrica(s1)
`endif
    );

    transposicao_matriz_seq #(.ROWS(1), .COLS(1), .DATA_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .matrix_A(m2), .m_transposta_A(o2),
        .busy(b2), .done(d2)
`ifdef TRANSPOSE_SYMM_CHECK_EN
        , .simetrica(s2)
`endif
    );

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [199:0] transp(input logic [199:0] a, input int rows, input int cols);
        logic [199:0] t;
        t = '0;
        for (int rr = 0; rr < rows; rr++)
            for (int cc = 0; cc < cols; cc++)
                t[(cc*rows+rr)*8 +: 8] = a[(rr*cols+cc)*8 +: 8];
        return t;
    endfunction

    task automatic drive(input int sel, input logic s, input logic [199:0] m);
        case (sel)
            0: begin st0 = s; m0 = m; end
            1: begin st1 = s; m1 = m[47:0]; end
            default: begin st2 = s; m2 = m[7:0]; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic s);
        case (sel)
            0: st0 = s;
            1: st1 = s;
            default: st2 = s;
        endcase
    endtask

    // One job on instance sel; optional start re-pulse or reset abort at RUN sample n.
    task automatic job(input int sel, input logic [199:0] m, input int repulse_at, input int rst_at);
        int rows, cols, n, bc;
        case (sel)
            0: begin rows = 5; cols = 5; end
            1: begin rows = 2; cols = 3; end
            default: begin rows = 1; cols = 1; end
        endcase
        n = 0;
        drive(sel, 1'b1, m);
        q.push_back(transp(m, rows, cols));
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        bc = int'(bz[sel]);
        chk($sformatf("busy_on_accept%0d", sel), 200'(bz[sel]), 200'd1);
        while (!dn[sel] && n < 60) begin
            if (n == repulse_at) drive(sel, 1'b1, ~m);
            else set_start(sel, 1'b0);
            @(posedge clk); #1;
            n++;
            if (bz[sel]) bc++;
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 200'(bz[sel]), 200'd0);
                chk("abort_out", ov[sel], 200'd0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", 200'(dn[sel]), 200'd0);
                end
                rst_n = 1'b1;
                void'(q.pop_back());
                return;
            end
        end
        set_start(sel, 1'b0);
        chk($sformatf("latency%0d", sel), 200'(n), 200'(rows*cols+1));
        chk($sformatf("busy_cycles%0d", sel), 200'(bc), 200'(rows*cols));
        chk($sformatf("busy_at_done%0d", sel), 200'(bz[sel]), 200'd0);
        if (q.size() == 0) chk("scoreboard_empty", 200'd1, 200'd0);
        else chk($sformatf("result%0d", sel), ov[sel], q.pop_front());
        @(posedge clk); #1;
        chk($sformatf("done_pulse%0d", sel), 200'(dn[sel]), 200'd0);
        chk($sformatf("held%0d", sel), ov[sel], transp(m, rows, cols));
    endtask

    initial begin
        logic [199:0] a;
        logic [199:0] ramp;
        int           extra_done;

        rst_n = 1'b0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        m0 = '0; m1 = '0; m2 = '0;
        #1;
        chk("rst_out0", ov[0], 200'd0);
        chk("rst_out1", ov[1], 200'd0);
        chk("rst_busy", 200'(bz), 200'd0);
        chk("rst_done", 200'(dn), 200'd0);
`ifdef TRANSPOSE_SYMM_CHECK_EN
        chk("rst_simetrica", 200'(s0), 200'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 25; i++) ramp[i*8 +: 8] = 8'(i);
        job(0, ramp, -1, -1);
        chk("t_c1_r3", 200'(o0[(1*5+3)*8 +: 8]), 200'd16);
        chk("t_c4_r0", 200'(o0[(4*5+0)*8 +: 8]), 200'd4);

        job(1, 200'h06_05_04_03_02_01, -1, -1);
        chk("t2x3_flat", 200'(o1), 200'h06_03_05_02_04_01);

        job(2, 200'hA5, -1, -1);
        chk("t1x1", 200'(o2), 200'hA5);

        a = ramp;
        a[1*8 +: 8] = 8'h80;
        a[5*8 +: 8] = 8'h7F;
        job(0, a, -1, -1);
        chk("neg_t10", 200'(o0[5*8 +: 8]), 200'h80);
        chk("neg_t01", 200'(o0[1*8 +: 8]), 200'h7F);

        for (int i = 0; i < 25; i++) a[i*8 +: 8] = 8'($urandom_range(0, 255));
        job(0, a, 10, -1);
        extra_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (d0) extra_done++;
        end
        chk("no_queued_start", 200'(extra_done), 200'd0);

        job(0, ~ramp, -1, 12);
        chk("after_abort_out", ov[0], 200'd0);
        for (int i = 0; i < 25; i++) a[i*8 +: 8] = 8'(200 - i * 3);
        job(0, a, -1, -1);

`ifdef TRANSPOSE_SYMM_CHECK_EN
        for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 5; cc++)
                a[(rr*5+cc)*8 +: 8] = 8'(rr + cc + 17);
        job(0, a, -1, -1);
        chk("symm_yes", 200'(s0), 200'd1);
        a[(3*5+4)*8 +: 8] = a[(3*5+4)*8 +: 8] ^ 8'h01;
        job(0, a, -1, -1);
        chk("symm_no", 200'(s0), 200'd0);
        job(1, 200'h01_01_01_01_01_01, -1, -1);
        chk("symm_rect", 200'(s1), 200'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
